// File: rtl/i2c_register_slave.sv
// i2c_register_slave: I2C target with 7-bit addressing that exposes an 8-bit
// register space through a synchronous read/write strobe port. SCL/SDA are
// oversampled on clk, there is no clock stretching, and SDA is open-drain.
module i2c_register_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h36
) (
  input  logic       rstn,
  input  logic       clk,
  input  logic       scl,
  inout  wire        sda,
  output logic       busy,
  output logic [7:0] reg_addr,
  input  logic [7:0] reg_rdata,
  output logic       reg_rd,
  output logic       reg_wr,
  output logic [7:0] reg_wdata
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RACK      = 4'd8,
    ST_IGNORE    = 4'd9
  } state_t;

  // Synchronizer and history flops; idle bus level is high.
  logic scl_meta_r, scl_sync_r, scl_hist_r;
  logic sda_meta_r, sda_sync_r, sda_hist_r;

  // Protocol state.
  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] tx_r;
  logic       byte_done_r;
  logic       rw_r;
  logic       ack_r;
  logic       sda_oe_r;
  logic       busy_r;
  logic [7:0] reg_addr_r;
  logic       reg_rd_r;
  logic       reg_wr_r;
  logic [7:0] reg_wdata_r;

  // Edge and bus-condition strobes derived from synchronized samples.
  logic scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] shift_next_s;

  assign scl_rise_s   = scl_sync_r & ~scl_hist_r;
  assign scl_fall_s   = ~scl_sync_r & scl_hist_r;
  assign start_s      = scl_sync_r & scl_hist_r & sda_hist_r & ~sda_sync_r;
  assign stop_s       = scl_sync_r & scl_hist_r & ~sda_hist_r & sda_sync_r;
  assign shift_next_s = {shift_r[6:0], sda_sync_r};

  assign sda       = sda_oe_r ? 1'b0 : 1'bz;
  assign busy      = busy_r;
  assign reg_addr  = reg_addr_r;
  assign reg_rd    = reg_rd_r;
  assign reg_wr    = reg_wr_r;
  assign reg_wdata = reg_wdata_r;

  // Two-flop synchronizers for scl/sda followed by a one-flop history stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_hist_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_meta_r <= scl;
      scl_sync_r <= scl_meta_r;
      scl_hist_r <= scl_sync_r;
      sda_meta_r <= sda;
      sda_sync_r <= sda_meta_r;
      sda_hist_r <= sda_sync_r;
    end
  end

  // Protocol FSM with registered SDA enable, pointer and register strobes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      tx_r        <= 8'd0;
      byte_done_r <= 1'b0;
      rw_r        <= 1'b0;
      ack_r       <= 1'b1;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      reg_addr_r  <= 8'd0;
      reg_rd_r    <= 1'b0;
      reg_wr_r    <= 1'b0;
      reg_wdata_r <= 8'd0;
    end else begin
      reg_rd_r <= 1'b0;
      reg_wr_r <= 1'b0;
      // The pointer advances in the cycle after each write strobe.
      if (reg_wr_r) begin
        reg_addr_r <= reg_addr_r + 8'd1;
      end
      if (start_s) begin
        state_r     <= ST_ADDR;
        bit_cnt_r   <= 3'd0;
        byte_done_r <= 1'b0;
        sda_oe_r    <= 1'b0;
        busy_r      <= 1'b0;
      end else if (stop_s) begin
        state_r     <= ST_IDLE;
        bit_cnt_r   <= 3'd0;
        byte_done_r <= 1'b0;
        sda_oe_r    <= 1'b0;
        busy_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_IGNORE: begin
            sda_oe_r <= 1'b0;
          end
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise_s && !byte_done_r) begin
              shift_r   <= shift_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                byte_done_r <= 1'b1;
                if (state_r == ST_PTR) begin
                  reg_addr_r <= shift_next_s;
                end else if (state_r == ST_WDATA) begin
                  reg_wdata_r <= shift_next_s;
                  reg_wr_r    <= 1'b1;
                end
              end
            end else if (scl_fall_s && byte_done_r) begin
              byte_done_r <= 1'b0;
              case (state_r)
                ST_ADDR: begin
                  if (shift_r[7:1] == SLAVE_ADDR) begin
                    state_r  <= ST_ADDR_ACK;
                    sda_oe_r <= 1'b1;
                    busy_r   <= 1'b1;
                    rw_r     <= shift_r[0];
                  end else begin
                    state_r <= ST_IGNORE;
                  end
                end
                ST_PTR: begin
                  state_r  <= ST_PTR_ACK;
                  sda_oe_r <= 1'b1;
                end
                default: begin
                  state_r  <= ST_WDATA_ACK;
                  sda_oe_r <= 1'b1;
                end
              endcase
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_r <= 3'd0;
              if (rw_r) begin
                // Load the first read byte and advance the pointer past it.
                state_r    <= ST_RDATA;
                tx_r       <= reg_rdata;
                sda_oe_r   <= ~reg_rdata[7];
                reg_rd_r   <= 1'b1;
                reg_addr_r <= reg_addr_r + 8'd1;
              end else begin
                state_r  <= ST_PTR;
                sda_oe_r <= 1'b0;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall_s) begin
              state_r   <= ST_WDATA;
              sda_oe_r  <= 1'b0;
              bit_cnt_r <= 3'd0;
            end
          end
          ST_RDATA: begin
            if (scl_fall_s) begin
              if (bit_cnt_r == 3'd7) begin
                state_r  <= ST_RACK;
                sda_oe_r <= 1'b0;
              end else begin
                tx_r      <= {tx_r[6:0], 1'b0};
                sda_oe_r  <= ~tx_r[6];
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          ST_RACK: begin
            if (scl_rise_s) begin
              ack_r <= sda_sync_r;
            end else if (scl_fall_s) begin
              bit_cnt_r <= 3'd0;
              if (!ack_r) begin
                state_r    <= ST_RDATA;
                tx_r       <= reg_rdata;
                sda_oe_r   <= ~reg_rdata[7];
                reg_rd_r   <= 1'b1;
                reg_addr_r <= reg_addr_r + 8'd1;
              end else begin
                state_r  <= ST_IGNORE;
                sda_oe_r <= 1'b0;
                busy_r   <= 1'b0;
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
